issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 111 +++++++++++
 tb/tb_issue_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue
//   Dual-slot in-order instruction issue queue on a circular buffer.
//   Up to two entries are accepted per cycle (slot 1 before slot 2) and up
//   to two are consumed per cycle from the head. Outputs come from
//   registered state only, so there is no input-to-output path.
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    synchronous active-high reset
//   line1/2_in_valid_i       enqueue requests, slot 1 / slot 2
//   line1/2_in_bus_i         enqueue payloads
//   allowin_o                at least two free entries
//   line1/2_out_valid_o      head / head+1 entry present
//   line1/2_out_bus_o        payload at head / head+1
//   launch_cnt_i             entries consumed this cycle (0..2, 3 illegal)
//   flush_i                  discard all entries
//   count_o                  occupied entries
//   error_o                  sticky protocol-violation flag
module issue_queue #(
   parameter int WIDTH = 172,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     line1_in_valid_i,
   input  logic                     line2_in_valid_i,
   input  logic [WIDTH-1:0]         line1_in_bus_i,
   input  logic [WIDTH-1:0]         line2_in_bus_i,
   output logic                     allowin_o,
   output logic                     line1_out_valid_o,
   output logic                     line2_out_valid_o,
   output logic [WIDTH-1:0]         line1_out_bus_o,
   output logic [WIDTH-1:0]         line2_out_bus_o,
   input  logic [1:0]               launch_cnt_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     error_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             error_q, error_d;

   logic [1:0]       enq, deq, launch_lim;
   logic             drop, bad_launch, we_a, we_b;
   logic [PW-1:0]    tail_p1, head_p1;
   logic [WIDTH-1:0] wa_data;

   assign allowin_o = (count_q <= CW'(DEPTH - 2));
   assign tail_p1   = tail_q + PW'(1);
   assign head_p1   = head_q + PW'(1);

   always_comb begin
      drop       = (line1_in_valid_i | line2_in_valid_i) & ~allowin_o;
      enq        = allowin_o ? ({1'b0, line1_in_valid_i} + {1'b0, line2_in_valid_i}) : 2'd0;
      // launch of 3 is treated as 2 after being flagged
      launch_lim = (launch_cnt_i == 2'd3) ? 2'd2 : launch_cnt_i;
      bad_launch = (launch_cnt_i == 2'd3) ||
                   ({{(CW-2){1'b0}}, launch_cnt_i} > count_q);
      // when launch exceeds occupancy, count is at most 1 so it fits in 2 bits
      deq        = ({{(CW-2){1'b0}}, launch_lim} > count_q) ? count_q[1:0] : launch_lim;
      // slot 2 alone compacts into the tail position
      wa_data    = line1_in_valid_i ? line1_in_bus_i : line2_in_bus_i;
      we_a       = ~reset & ~flush_i & (enq != 2'd0);
      we_b       = ~reset & ~flush_i & allowin_o & line1_in_valid_i & line2_in_valid_i;

      head_d     = head_q + PW'(deq);
      tail_d     = tail_q + PW'(enq);
      count_d    = count_q + CW'(enq) - CW'(deq);
      error_d    = error_q | drop | bad_launch;

      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         error_d = error_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   // storage is not reset; validity is tracked by count_q alone
   always_ff @(posedge clk) begin
      if (we_a) mem_q[tail_q]  <= wa_data;
      if (we_b) mem_q[tail_p1] <= line2_in_bus_i;
   end

   assign line1_out_valid_o = (count_q != '0);
   assign line2_out_valid_o = (count_q >= CW'(2));
   assign line1_out_bus_o   = mem_q[head_q];
   assign line2_out_bus_o   = mem_q[head_p1];
   assign count_o           = count_q;
   assign error_o           = error_q;

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;

   localparam int W = 172;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          v1 = 1'b0, v2 = 1'b0;
   logic [W-1:0]  b1 = '0, b2 = '0;
   logic          allowin;
   logic          ov1, ov2;
   logic [W-1:0]  ob1, ob2;
   logic [1:0]    launch = 2'd0;
   logic          flush = 1'b0;
   logic [3:0]    count;
   logic          error;

   issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clk               (clk),
      .reset             (reset),
      .line1_in_valid_i  (v1),
      .line2_in_valid_i  (v2),
      .line1_in_bus_i    (b1),
      .line2_in_bus_i    (b2),
      .allowin_o         (allowin),
      .line1_out_valid_o (ov1),
      .line2_out_valid_o (ov2),
      .line1_out_bus_o   (ob1),
      .line2_out_bus_o   (ob2),
      .launch_cnt_i      (launch),
      .flush_i           (flush),
      .count_o           (count),
      .error_o           (error)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   logic [W-1:0] sb [$];
   logic         m_err = 1'b0;
   int           seq   = 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_bus();
      logic [191:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // outputs against the scoreboard, sampled 1 time unit after the edge
   task automatic check_outputs();
      int sz;
      sz = sb.size();
      chk("count",   W'(count),   W'(sz));
      chk("allowin", W'(allowin), W'((D - sz) >= 2));
      chk("ov1",     W'(ov1),     W'(sz >= 1));
      chk("ov2",     W'(ov2),     W'(sz >= 2));
      chk("error",   W'(error),   W'(m_err));
      if (sz >= 1 && ov1) chk("bus1", ob1, sb[0]);
      if (sz >= 2 && ov2) chk("bus2", ob2, sb[1]);
   endtask

   task automatic step(input bit i1, input logic [W-1:0] d1,
                       input bit i2, input logic [W-1:0] d2,
                       input logic [1:0] l, input bit fl, input bit rs);
      int sz, lim, dq;
      bit allow;
      v1 = i1; b1 = d1; v2 = i2; b2 = d2;
      launch = l; flush = fl; reset = rs;
      @(posedge clk);
      sz = sb.size();
      if (rs) begin
         sb.delete();
         m_err = 1'b0;
      end else if (fl) begin
         sb.delete();
      end else begin
         allow = (D - sz) >= 2;
         lim   = (l == 2'd3) ? 2 : int'(l);
         if (l == 2'd3 || int'(l) > sz) m_err = 1'b1;
         dq    = (lim > sz) ? sz : lim;
         if ((i1 || i2) && !allow) m_err = 1'b1;
         for (int k = 0; k < dq; k++) void'(sb.pop_front());
         if (allow) begin
            if (i1) sb.push_back(d1);
            if (i2) sb.push_back(d2);
         end
      end
      #1;
      v1 = 1'b0; v2 = 1'b0; launch = 2'd0; flush = 1'b0; reset = 1'b0;
      check_outputs();
   endtask

   task automatic dual(input logic [1:0] l);
      step(1'b1, W'(seq), 1'b1, W'(seq + 1), l, 1'b0, 1'b0);
      seq += 2;
   endtask

   initial begin
      // reset state
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      chk("rst_allowin", W'(allowin), W'(1));
      chk("rst_ov1",     W'(ov1),     W'(0));

      // single slot-1 enqueue
      step(1'b1, W'(8'h11), 1'b0, '0, 2'd0, 1'b0, 1'b0);
      chk("single_bus", ob1, W'(8'h11));
      chk("single_cnt", W'(count), W'(1));

      // slot-2-only compaction, then drain
      step(1'b0, '0, 1'b1, W'(8'h22), 2'd0, 1'b0, 1'b0);
      chk("compact_bus2", ob2, W'(8'h22));
      step(1'b0, '0, 1'b0, '0, 2'd2, 1'b0, 1'b0);

      // fill to full, fifth dual request dropped
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) dual(2'd0);
      chk("full_cnt",     W'(count),   W'(8));
      chk("full_allowin", W'(allowin), W'(0));
      dual(2'd0);
      chk("drop_err", W'(error), W'(1));

      // streaming across wrap, steady count 2
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      seq = 1;
      dual(2'd0);
      for (int i = 0; i < 12; i++) dual(2'd2);
      chk("stream_cnt", W'(count), W'(2));
      chk("stream_err", W'(error), W'(0));
      chk("stream_head", ob1, W'(25));

      // flush at count 5 with concurrent enqueue and launch
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      dual(2'd0); dual(2'd0);
      step(1'b1, W'(8'h55), 1'b0, '0, 2'd0, 1'b0, 1'b0);
      chk("pre_flush_cnt", W'(count), W'(5));
      step(1'b1, rnd_bus(), 1'b1, rnd_bus(), 2'd2, 1'b1, 1'b0);
      chk("flush_cnt", W'(count), W'(0));

      // over-launch sets sticky error; flush keeps it, reset clears it
      step(1'b1, W'(8'h33), 1'b0, '0, 2'd0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 2'd2, 1'b0, 1'b0);
      chk("overlaunch_err", W'(error), W'(1));
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b1, 1'b0);
      chk("err_after_flush", W'(error), W'(1));
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      chk("err_after_reset", W'(error), W'(0));

      // launch 3 with plenty of entries is still illegal, consumes two
      dual(2'd0); dual(2'd0);
      step(1'b0, '0, 1'b0, '0, 2'd3, 1'b0, 1'b0);
      chk("launch3_cnt", W'(count), W'(2));
      chk("launch3_err", W'(error), W'(1));

      // reset mid-operation at count 6 with concurrent enqueue
      step(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
      dual(2'd0); dual(2'd0); dual(2'd0);
      step(1'b1, rnd_bus(), 1'b1, rnd_bus(), 2'd1, 1'b0, 1'b1);
      chk("midrst_cnt", W'(count), W'(0));

      // random traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         logic [1:0] l;
         r = $urandom_range(0, 99);
         l = (r < 3) ? 2'd3 : 2'($urandom_range(0, 2));
         step(1'($urandom_range(0, 1)), rnd_bus(), 1'($urandom_range(0, 1)), rnd_bus(),
              l, (r >= 3 && r < 6), (r == 99));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
